// File: rtl/seq_mul16.sv
// rtl/seq_mul16.sv - 16x16 shift-add sequential multiplier, signed or unsigned
// Sign-magnitude core: operands are reduced to magnitudes at capture, result re-signed at DONE entry.
module seq_mul16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_mode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [15:0] r_mcand;
  logic [15:0] r_acc;
  logic [15:0] r_mult;
  logic        r_neg;
  logic [31:0] r_product;

  logic        w_capture;
  logic        w_step;
  logic        w_finish;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [15:0] w_a_mag;
  logic [15:0] w_b_mag;
  logic [16:0] w_sum;
  logic [15:0] w_acc_next;
  logic [15:0] w_mult_next;
  logic [31:0] w_mag;
  logic [31:0] w_result;

  assign w_a_neg = signed_mode & a[15];
  assign w_b_neg = signed_mode & b[15];
  assign w_a_mag = w_a_neg ? (~a + 16'd1) : a;
  assign w_b_mag = w_b_neg ? (~b + 16'd1) : b;

  // The 17th sum bit is the carry that shifts into the accumulator MSB.
  assign w_sum       = {1'b0, r_acc} + (r_mult[0] ? {1'b0, r_mcand} : 17'd0);
  assign w_acc_next  = w_sum[16:1];
  assign w_mult_next = {w_sum[0], r_mult[15:1]};
  assign w_mag       = {w_acc_next, w_mult_next};
  assign w_result    = r_neg ? (~w_mag + 32'd1) : w_mag;

  assign product = r_product;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_capture    = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_capture    = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == 4'd15) begin
          w_finish     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_mcand   <= 16'd0;
      r_acc     <= 16'd0;
      r_mult    <= 16'd0;
      r_neg     <= 1'b0;
      r_product <= 32'd0;
    end else begin
      if (w_capture) begin
        r_cnt   <= 4'd0;
        r_mcand <= w_a_mag;
        r_mult  <= w_b_mag;
        r_acc   <= 16'd0;
        r_neg   <= w_a_neg ^ w_b_neg;
      end else if (w_step) begin
        r_cnt  <= r_cnt + 4'd1;
        r_acc  <= w_acc_next;
        r_mult <= w_mult_next;
      end
      if (w_finish) begin
        r_product <= w_result;
      end
    end
  end

endmodule
